// File: rtl/pll_lock_reset.sv
// pll_lock_reset: reset sequencer fed by the board PLL lock signal.
// Synchronises lock_in into the clock domain, holds the downstream reset
// until lock has been stable for HOLD_CYCLES cycles, re-asserts it when lock
// is lost for DROP_CYCLES cycles, and keeps loss-of-lock statistics.
//
// Handshake note: this block has no valid/ready transfer interface. The
// `ready` output is a level that simply means "downstream logic is out of
// reset". It always equals ~rst_out.
module pll_lock_reset #(
  parameter int HOLD_CYCLES = 1024,
  parameter int DROP_CYCLES = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       lock_in,
  input  logic       clear_stat,
  output logic       rst_out,
  output logic       ready,
  output logic [7:0] lost_count,
  output logic       lost_sticky,
  output logic [1:0] state
);

  localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam int DW = (DROP_CYCLES > 1) ? $clog2(DROP_CYCLES) : 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
  localparam logic [DW-1:0] DROP_LAST = DW'(DROP_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_WAIT = 2'd0,
    ST_STAB = 2'd1,
    ST_RUN  = 2'd2,
    ST_LOST = 2'd3
  } state_t;

  state_t        r_state;
  logic          r_sync1;
  logic          r_lock_s;
  logic [HW-1:0] r_hold_cnt;
  logic [DW-1:0] r_drop_cnt;
  logic          r_rst_out;
  logic          r_ready;
  logic [7:0]    r_lost_count;
  logic          r_lost_sticky;
  logic          w_loss_event;

  // A loss event is the RUN -> LOST transition; the stats block keys off it.
  assign w_loss_event = (r_state == ST_RUN) && !r_lock_s && (r_drop_cnt == DROP_LAST);

  // Two-flop synchroniser for the asynchronous PLL lock signal.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_sync1  <= 1'b0;
      r_lock_s <= 1'b0;
    end else begin
      r_sync1  <= lock_in;
      r_lock_s <= r_sync1;
    end
  end

  // Lock sequencing FSM; rst_out/ready are registered from the next state so
  // they change on the same edge as the state transition.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state    <= ST_WAIT;
      r_hold_cnt <= '0;
      r_drop_cnt <= '0;
      r_rst_out  <= 1'b1;
      r_ready    <= 1'b0;
    end else begin
      case (r_state)
        ST_WAIT: begin
          r_rst_out <= 1'b1;
          r_ready   <= 1'b0;
          if (r_lock_s) begin
            r_state    <= ST_STAB;
            r_hold_cnt <= '0;
          end
        end
        ST_STAB: begin
          if (!r_lock_s) begin
            // Any unlock during stabilisation restarts the full hold count.
            r_state    <= ST_WAIT;
            r_hold_cnt <= '0;
          end else if (r_hold_cnt == HOLD_LAST) begin
            r_state    <= ST_RUN;
            r_drop_cnt <= '0;
            r_rst_out  <= 1'b0;
            r_ready    <= 1'b1;
          end else begin
            r_hold_cnt <= r_hold_cnt + HW'(1);
          end
        end
        ST_RUN: begin
          if (r_lock_s) begin
            r_drop_cnt <= '0;
          end else if (r_drop_cnt == DROP_LAST) begin
            r_state   <= ST_LOST;
            r_rst_out <= 1'b1;
            r_ready   <= 1'b0;
          end else begin
            r_drop_cnt <= r_drop_cnt + DW'(1);
          end
        end
        ST_LOST: begin
          // One extra reset cycle so every loss yields at least two reset
          // cycles, even if lock has already come back.
          r_state   <= ST_WAIT;
          r_rst_out <= 1'b1;
          r_ready   <= 1'b0;
        end
        default: begin
          r_state   <= ST_WAIT;
          r_rst_out <= 1'b1;
          r_ready   <= 1'b0;
        end
      endcase
    end
  end

  // Loss statistics: a clear on the same edge as a loss is applied first,
  // so the event still registers (count 1, sticky set).
  always_ff @(posedge clock) begin
    if (reset) begin
      r_lost_count  <= 8'd0;
      r_lost_sticky <= 1'b0;
    end else begin
      if (clear_stat) begin
        r_lost_count  <= 8'd0;
        r_lost_sticky <= 1'b0;
      end
      if (w_loss_event) begin
        r_lost_sticky <= 1'b1;
        if (clear_stat) begin
          r_lost_count <= 8'd1;
        end else if (r_lost_count != 8'hFF) begin
          r_lost_count <= r_lost_count + 8'd1;
        end
      end
    end
  end

  assign rst_out     = r_rst_out;
  assign ready       = r_ready;
  assign lost_count  = r_lost_count;
  assign lost_sticky = r_lost_sticky;
  assign state       = r_state;

endmodule

// File: tb/tb_pll_lock_reset.sv
// tb_pll_lock_reset: directed scenarios plus a randomized run checked against
// a streak-counting reference model. Two instances share the stimulus: one
// with HOLD=16/DROP=4 and one with the minimum HOLD=1/DROP=1.
module tb_pll_lock_reset;

  logic       clock;
  logic       reset;
  logic       lock_in;
  logic       clear_stat;

  logic       a_rst, a_ready, a_sticky;
  logic [7:0] a_lost;
  logic [1:0] a_state;
  logic       b_rst, b_ready, b_sticky;
  logic [7:0] b_lost;
  logic [1:0] b_state;

  int n_checks = 0;
  int n_fail   = 0;

  // ---------------- clock / reset block ----------------
  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached, got running, required finished");
    $fatal(1, "watchdog");
  end

  pll_lock_reset #(.HOLD_CYCLES(16), .DROP_CYCLES(4)) dut_a (
    .clock(clock), .reset(reset), .lock_in(lock_in), .clear_stat(clear_stat),
    .rst_out(a_rst), .ready(a_ready), .lost_count(a_lost),
    .lost_sticky(a_sticky), .state(a_state)
  );

  pll_lock_reset #(.HOLD_CYCLES(1), .DROP_CYCLES(1)) dut_b (
    .clock(clock), .reset(reset), .lock_in(lock_in), .clear_stat(clear_stat),
    .rst_out(b_rst), .ready(b_ready), .lost_count(b_lost),
    .lost_sticky(b_sticky), .state(b_state)
  );

  // ---------------- reference model ----------------
  // mode: 0 = holding reset (counting a streak of good lock samples),
  //       1 = running, 2 = one-cycle penalty after a loss.
  int m_hold [2] = '{16, 1};
  int m_drop [2] = '{4, 1};
  int m_mode [2];
  int m_hi   [2];
  int m_lo   [2];
  int m_lost [2];
  bit m_stick[2];
  bit pipe[$];

  task automatic model_step();
    bit ls;
    bit ev;
    if (reset) begin
      pipe = '{1'b0, 1'b0};
      for (int i = 0; i < 2; i++) begin
        m_mode[i] = 0; m_hi[i] = 0; m_lo[i] = 0; m_lost[i] = 0; m_stick[i] = 0;
      end
    end else begin
      ls = pipe[0];
      pipe.pop_front();
      pipe.push_back(lock_in);
      for (int i = 0; i < 2; i++) begin
        ev = 0;
        if (m_mode[i] == 0) begin
          // One good sample enters stabilisation, then HOLD more release.
          if (ls) begin
            m_hi[i]++;
            if (m_hi[i] == m_hold[i] + 1) begin
              m_mode[i] = 1;
              m_lo[i]   = 0;
            end
          end else begin
            m_hi[i] = 0;
          end
        end else if (m_mode[i] == 1) begin
          if (!ls) begin
            m_lo[i]++;
            if (m_lo[i] == m_drop[i]) begin
              m_mode[i] = 2;
              ev = 1;
            end
          end else begin
            m_lo[i] = 0;
          end
        end else begin
          m_mode[i] = 0;
          m_hi[i]   = 0;
        end
        if (clear_stat) begin
          m_lost[i]  = 0;
          m_stick[i] = 0;
        end
        if (ev) begin
          m_stick[i] = 1;
          m_lost[i]  = (m_lost[i] >= 255) ? 255 : m_lost[i] + 1;
        end
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clock);
    model_step();
    #1;
  endtask

  task automatic wait_run_a();
    int  n;
    bit  ok;
    lock_in = 1'b1;
    ok = 0;
    n  = 0;
    while (!ok && n < 100) begin
      tick();
      n++;
      if (a_rst === 1'b0 && a_state === 2'd2) ok = 1;
    end
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL wait_run: rst_out=%b state=%0d after %0d cycles, required rst_out=0 state=2", a_rst, a_state, n);
    end
  endtask

  // Drop lock on A for exactly DROP_CYCLES samples; optional clear on the
  // edge where A enters LOST (edge 6 counting from the first low sample).
  task automatic lose_a(input bit with_clear);
    lock_in = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      if (k == 5) lock_in = 1'b1;
      if (k == 6 && with_clear) clear_stat = 1'b1;
      tick();
      clear_stat = 1'b0;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1; lock_in = 1'b1; clear_stat = 1'b0;
    repeat (3) tick();
    n_checks++; if (a_state !== 2'd0) begin n_fail++; $display("FAIL reset_state: got %0d required 0", a_state); end
    n_checks++; if (a_rst !== 1'b1) begin n_fail++; $display("FAIL reset_rst: got %b required 1", a_rst); end
    n_checks++; if (a_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %b required 0", a_ready); end
    n_checks++; if (a_lost !== 8'd0) begin n_fail++; $display("FAIL reset_lost: got %0d required 0", a_lost); end
    n_checks++; if (a_sticky !== 1'b0) begin n_fail++; $display("FAIL reset_sticky: got %b required 0", a_sticky); end
    n_checks++; if (b_rst !== 1'b1) begin n_fail++; $display("FAIL reset_rst_b: got %b required 1", b_rst); end
  endtask

  task automatic test_power_up();
    reset = 1'b0;
    for (int k = 1; k <= 22; k++) begin
      tick();
      if (k == 2) begin
        n_checks++; if (a_state !== 2'd0) begin n_fail++; $display("FAIL pwr_state_e2: got %0d required 0", a_state); end
      end
      if (k == 3) begin
        n_checks++; if (a_state !== 2'd1) begin n_fail++; $display("FAIL pwr_state_e3: got %0d required 1", a_state); end
        n_checks++; if (b_rst !== 1'b1) begin n_fail++; $display("FAIL pwr_b_rst_e3: got %b required 1", b_rst); end
      end
      if (k == 4) begin
        n_checks++; if (b_rst !== 1'b0 || b_state !== 2'd2) begin n_fail++; $display("FAIL pwr_b_release: rst=%b state=%0d required 0/2", b_rst, b_state); end
      end
      if (k == 18) begin
        n_checks++; if (a_rst !== 1'b1 || a_state !== 2'd1) begin n_fail++; $display("FAIL pwr_e18: rst=%b state=%0d required 1/1", a_rst, a_state); end
      end
      if (k == 19) begin
        n_checks++; if (a_rst !== 1'b0 || a_ready !== 1'b1 || a_state !== 2'd2) begin
          n_fail++; $display("FAIL pwr_release: rst=%b ready=%b state=%0d required 0/1/2", a_rst, a_ready, a_state);
        end
      end
    end
  endtask

  task automatic test_stab_drop();
    reset = 1'b1; tick(); reset = 1'b0;
    lock_in = 1'b1;
    for (int k = 1; k <= 12; k++) tick();
    n_checks++; if (a_state !== 2'd1) begin n_fail++; $display("FAIL stab_in_stab: got %0d required 1", a_state); end
    lock_in = 1'b0; tick(); lock_in = 1'b1;
    for (int j = 1; j <= 20; j++) begin
      tick();
      if (j == 2) begin
        n_checks++; if (a_state !== 2'd0) begin n_fail++; $display("FAIL stab_back_wait: got %0d required 0", a_state); end
      end
      if (j == 18) begin
        n_checks++; if (a_rst !== 1'b1) begin n_fail++; $display("FAIL stab_e18: rst=%b required 1", a_rst); end
      end
      if (j == 19) begin
        n_checks++; if (a_rst !== 1'b0) begin n_fail++; $display("FAIL stab_release: rst=%b required 0", a_rst); end
      end
    end
    n_checks++; if (a_lost !== 8'd0) begin n_fail++; $display("FAIL stab_lost: got %0d required 0", a_lost); end
  endtask

  task automatic test_glitch();
    lock_in = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      if (k == 4) lock_in = 1'b1;
      tick();
      n_checks++; if (a_rst !== 1'b0) begin n_fail++; $display("FAIL glitch3_rst k=%0d: got %b required 0", k, a_rst); end
    end
    n_checks++; if (a_lost !== 8'd0 || a_state !== 2'd2) begin n_fail++; $display("FAIL glitch3_stats: lost=%0d state=%0d required 0/2", a_lost, a_state); end
    lock_in = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      if (k == 5) lock_in = 1'b1;
      tick();
      if (k == 5) begin
        n_checks++; if (a_rst !== 1'b0) begin n_fail++; $display("FAIL glitch4_e5: rst=%b required 0", a_rst); end
      end
      if (k == 6) begin
        n_checks++; if (a_rst !== 1'b1 || a_state !== 2'd3) begin n_fail++; $display("FAIL glitch4_e6: rst=%b state=%0d required 1/3", a_rst, a_state); end
      end
      if (k == 7) begin
        n_checks++; if (a_state !== 2'd0) begin n_fail++; $display("FAIL glitch4_e7: state=%0d required 0", a_state); end
      end
    end
    n_checks++; if (a_lost !== 8'd1 || a_sticky !== 1'b1) begin n_fail++; $display("FAIL glitch4_stats: lost=%0d sticky=%b required 1/1", a_lost, a_sticky); end
  endtask

  task automatic test_clear_vs_event();
    for (int n = 0; n < 4; n++) begin
      wait_run_a();
      lose_a(1'b0);
    end
    n_checks++; if (a_lost !== 8'd5) begin n_fail++; $display("FAIL clr_pre: lost=%0d required 5", a_lost); end
    wait_run_a();
    lose_a(1'b1);
    n_checks++; if (a_state !== 2'd3) begin n_fail++; $display("FAIL clr_state: got %0d required 3", a_state); end
    n_checks++; if (a_lost !== 8'd1 || a_sticky !== 1'b1) begin n_fail++; $display("FAIL clr_same_edge: lost=%0d sticky=%b required 1/1", a_lost, a_sticky); end
    clear_stat = 1'b1; tick(); clear_stat = 1'b0;
    n_checks++; if (a_lost !== 8'd0 || a_sticky !== 1'b0) begin n_fail++; $display("FAIL clr_lone: lost=%0d sticky=%b required 0/0", a_lost, a_sticky); end
  endtask

  task automatic test_saturation();
    for (int n = 0; n < 260; n++) begin
      wait_run_a();
      lose_a(1'b0);
      n_checks++; if (a_state !== 2'd3) begin n_fail++; $display("FAIL sat_lost_state n=%0d: got %0d required 3", n, a_state); end
    end
    n_checks++; if (a_lost !== 8'd255 || a_sticky !== 1'b1) begin n_fail++; $display("FAIL sat_value: lost=%0d sticky=%b required 255/1", a_lost, a_sticky); end
    wait_run_a();
  endtask

  task automatic test_mid_run_reset();
    wait_run_a();
    reset = 1'b1; tick(); reset = 1'b0;
    n_checks++; if (a_rst !== 1'b1 || a_ready !== 1'b0 || a_state !== 2'd0) begin
      n_fail++; $display("FAIL mrr_edge: rst=%b ready=%b state=%0d required 1/0/0", a_rst, a_ready, a_state);
    end
    n_checks++; if (a_lost !== 8'd0 || a_sticky !== 1'b0) begin n_fail++; $display("FAIL mrr_stats: lost=%0d sticky=%b required 0/0", a_lost, a_sticky); end
    lock_in = 1'b1;
    for (int k = 1; k <= 19; k++) begin
      tick();
      if (k == 18) begin
        n_checks++; if (a_rst !== 1'b1) begin n_fail++; $display("FAIL mrr_e18: rst=%b required 1", a_rst); end
      end
      if (k == 19) begin
        n_checks++; if (a_rst !== 1'b0) begin n_fail++; $display("FAIL mrr_release: rst=%b required 0", a_rst); end
      end
    end
  endtask

  task automatic test_random();
    int         run_left;
    logic [1:0] exp_state;
    logic [7:0] exp_lost;
    logic [1:0] act_state;
    logic [7:0] act_lost;
    logic       act_rst, act_ready, act_sticky;
    reset = 1'b1; clear_stat = 1'b0; tick(); reset = 1'b0;
    run_left = 0;
    for (int c = 0; c < 4000; c++) begin
      if (run_left == 0) begin
        lock_in  = ~lock_in;
        run_left = lock_in ? $urandom_range(1, 60) : $urandom_range(1, 8);
      end
      run_left--;
      clear_stat = ($urandom_range(0, 49) == 0);
      reset      = ($urandom_range(0, 599) == 0);
      tick();
      for (int i = 0; i < 2; i++) begin
        act_state  = (i == 0) ? a_state  : b_state;
        act_rst    = (i == 0) ? a_rst    : b_rst;
        act_ready  = (i == 0) ? a_ready  : b_ready;
        act_lost   = (i == 0) ? a_lost   : b_lost;
        act_sticky = (i == 0) ? a_sticky : b_sticky;
        exp_state  = (m_mode[i] == 1) ? 2'd2 : (m_mode[i] == 2) ? 2'd3 : (m_hi[i] > 0) ? 2'd1 : 2'd0;
        exp_lost   = 8'(m_lost[i]);
        n_checks++; if (act_state !== exp_state) begin n_fail++; $display("FAIL rnd_state dut%0d c=%0d: got %0d required %0d", i, c, act_state, exp_state); end
        n_checks++; if (act_rst !== (m_mode[i] != 1)) begin n_fail++; $display("FAIL rnd_rst dut%0d c=%0d: got %b required %b", i, c, act_rst, (m_mode[i] != 1)); end
        n_checks++; if (act_ready !== (m_mode[i] == 1)) begin n_fail++; $display("FAIL rnd_ready dut%0d c=%0d: got %b required %b", i, c, act_ready, (m_mode[i] == 1)); end
        n_checks++; if (act_lost !== exp_lost) begin n_fail++; $display("FAIL rnd_lost dut%0d c=%0d: got %0d required %0d", i, c, act_lost, exp_lost); end
        n_checks++; if (act_sticky !== m_stick[i]) begin n_fail++; $display("FAIL rnd_sticky dut%0d c=%0d: got %b required %b", i, c, act_sticky, m_stick[i]); end
      end
    end
    reset = 1'b0; clear_stat = 1'b0;
  endtask

  // ---------------- sequence and final report ----------------
  initial begin
    reset = 1'b1; lock_in = 1'b0; clear_stat = 1'b0;
    test_reset();
    test_power_up();
    test_stab_drop();
    test_glitch();
    test_clear_vs_event();
    test_saturation();
    test_mid_run_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
